// File: rtl/opponent_status_rx.sv
`default_nettype none
// ============================================================================
// Module   : opponent_status_rx
// Purpose  : 8N1 UART receiver decoding the opponent board's status byte,
//            with a link watchdog that clears stale status.
// Revision : 1.0
// ============================================================================
module opponent_status_rx #(
    parameter int CLKS_PER_BIT = 564,
    parameter int TIMEOUT_CLKS = 6_500_000
) (
    input  logic pclk,
    input  logic rst,
    input  logic rx,
    output logic opponent_ready,
    output logic opponent_game_over,
    output logic opponent_victory,
    output logic opponent_in_game,
    output logic link_up,
    output logic frame_valid,
    output logic frame_error
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                w_cnt_clr;
    logic                w_shift;
    logic                w_accept;
    logic                w_reject;
    logic                w_marker_ok;

    assign w_marker_ok = (r_shift[7:5] == 3'b101) && !r_shift[4];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                        w_accept    = w_marker_ok;
                        w_reject    = !w_marker_ok;
                    end else begin
                        // Broken stop bit: park until the line returns high so
                        // a held-low line reports only once.
                        w_reject    = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_clr = 1'b1;
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_rx_meta          <= 1'b1;
            r_rx_s             <= 1'b1;
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_bit_idx          <= '0;
            r_shift            <= '0;
            r_tmo              <= '0;
            opponent_ready     <= 1'b0;
            opponent_game_over <= 1'b0;
            opponent_victory   <= 1'b0;
            opponent_in_game   <= 1'b0;
            link_up            <= 1'b0;
            frame_valid        <= 1'b0;
            frame_error        <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + c_CNT_W'(1);
            frame_valid <= w_accept;
            frame_error <= w_reject;

            if (r_state == S_IDLE) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_shift   <= {r_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // Accept has priority over watchdog expiry in the same cycle.
            if (w_accept) begin
                r_tmo              <= '0;
                opponent_ready     <= r_shift[0];
                opponent_game_over <= r_shift[1];
                opponent_victory   <= r_shift[2];
                opponent_in_game   <= r_shift[3];
                link_up            <= 1'b1;
            end else if (r_tmo == c_TMO_MAX) begin
                opponent_ready     <= 1'b0;
                opponent_game_over <= 1'b0;
                opponent_victory   <= 1'b0;
                opponent_in_game   <= 1'b0;
                link_up            <= 1'b0;
            end else begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opponent_status_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_opponent_status_rx
// Purpose  : Scoreboard bench for opponent_status_rx with directed frames.
// Revision : 1.0
// ============================================================================
module tb_opponent_status_rx;

    localparam int c_CPB = 16;
    localparam int c_TMO = 1000;

    logic pclk;
    logic rst;
    logic rx;
    logic opponent_ready, opponent_game_over, opponent_victory, opponent_in_game;
    logic link_up, frame_valid, frame_error;

    typedef struct packed {
        logic       is_valid;
        logic [3:0] flags;
        logic       link;
    } ev_t;

    ev_t     sb_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    longint  cyc = 0;
    longint  fv_cyc = 0;
    logic [3:0] cur_flags;

    opponent_status_rx #(
        .CLKS_PER_BIT(c_CPB),
        .TIMEOUT_CLKS(c_TMO)
    ) dut (
        .pclk              (pclk),
        .rst               (rst),
        .rx                (rx),
        .opponent_ready    (opponent_ready),
        .opponent_game_over(opponent_game_over),
        .opponent_victory  (opponent_victory),
        .opponent_in_game  (opponent_in_game),
        .link_up           (link_up),
        .frame_valid       (frame_valid),
        .frame_error       (frame_error)
    );

    wire [3:0] w_flags = {opponent_in_game, opponent_victory, opponent_game_over, opponent_ready};
    wire [6:0] w_all   = {frame_error, frame_valid, link_up, w_flags};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected event whenever the DUT pulses an outcome.
    always @(negedge pclk) begin
        if (rst && (frame_valid || frame_error)) begin
            chk("pulse_exclusive", 32'(frame_valid & frame_error), 32'd0);
            if (frame_valid) fv_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {30'd0, frame_error, frame_valid}, 32'd0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("ev_kind", 32'(frame_valid), 32'(e.is_valid));
                chk("ev_flags", 32'(w_flags), 32'(e.flags));
                chk("ev_link", 32'(link_up), 32'(e.link));
            end
        end
    end

    task automatic expect_ev(input logic v, input logic [3:0] f, input logic l);
        ev_t e;
        e.is_valid = v;
        e.flags    = f;
        e.link     = l;
        sb_q.push_back(e);
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (c_CPB) @(posedge pclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset_outputs", 32'(w_all), 32'd0);
        @(posedge pclk); #1;
        rst = 1'b1;
        idle(10);
        chk("post_reset_idle", 32'(w_all), 32'd0);

        // A1: ready only
        expect_ev(1'b1, 4'b0001, 1'b1);
        send(8'hA1, 1'b1);
        idle(10);
        chk("a1_flags", 32'(w_flags), 32'h1);
        chk("a1_link", 32'(link_up), 32'd1);

        // 61: bad marker, flags hold
        expect_ev(1'b0, 4'b0001, 1'b1);
        send(8'h61, 1'b1);
        idle(10);
        chk("bad_marker_hold", 32'(w_flags), 32'h1);

        // A2 with low stop, line held low, then AC
        expect_ev(1'b0, 4'b0001, 1'b1);
        send(8'hA2, 1'b0);
        rx = 1'b0;
        repeat (200) @(posedge pclk);
        #1;
        idle(10);
        chk("stop_err_hold", 32'(w_flags), 32'h1);
        expect_ev(1'b1, 4'b1100, 1'b1);
        send(8'hAC, 1'b1);
        idle(10);
        chk("ac_flags", 32'(w_flags), 32'hC);

        // Short glitch: no event expected
        rx = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        idle(40);
        chk("glitch_no_event", 32'(sb_q.size()), 32'd0);

        // Watchdog: link drops 1001 cycles after the accept pulse
        expect_ev(1'b1, 4'b0001, 1'b1);
        send(8'hA1, 1'b1);
        k = 0;
        while (link_up && k < 2000) begin
            @(negedge pclk);
            k++;
        end
        chk("timeout_link", 32'(link_up), 32'd0);
        chk("timeout_delay", 32'(cyc - fv_cyc), 32'd1001);
        chk("timeout_flags", 32'(w_flags), 32'd0);
        @(posedge pclk); #1;
        expect_ev(1'b1, 4'b0001, 1'b1);
        send(8'hA1, 1'b1);
        idle(10);
        chk("restore_ready", 32'(opponent_ready), 32'd1);
        chk("restore_link", 32'(link_up), 32'd1);

        // Reset during data bit 4 of A9
        expect_ev(1'b1, 4'b1001, 1'b1);
        send(8'hA9, 1'b1);
        idle(10);
        chk("a9_flags", 32'(w_flags), 32'h9);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(cur_flags[0] | 1'b1 ? 1'(8'hA9 >> i) : 1'b0);
        rx = 1'b0;
        repeat (8) @(posedge pclk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        chk("midframe_reset_out", 32'(w_all), 32'd0);
        @(posedge pclk); #1;
        rst = 1'b1;
        idle(30);
        chk("after_reset_quiet", 32'(w_all), 32'd0);
        expect_ev(1'b1, 4'b1001, 1'b1);
        send(8'hA9, 1'b1);
        idle(10);
        chk("reset_a9_ready", 32'(opponent_ready), 32'd1);
        chk("reset_a9_ingame", 32'(opponent_in_game), 32'd1);

        idle(20);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial cur_flags = 4'b0001;

endmodule
`default_nettype wire

// File: doc/opponent_status_rx.md
OPPONENT_STATUS_RX -- requirements
Module: opponent_status_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 564, pclk cycles per serial bit (65 MHz / 115200 baud).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 6_500_000, cycles without a valid frame before the link is declared down (100 ms).
REQ-003 SHALL have port pclk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx  input  1  serial line from the opponent board, asynchronous to pclk, idle high.
REQ-006 SHALL have port opponent_ready  output  1  opponent waits in multiplayer lobby; feeds opponent_ready of the background/mode logic.
REQ-007 SHALL have port opponent_game_over  output  1  opponent has lost.
REQ-008 SHALL have port opponent_victory  output  1  opponent has won.
REQ-009 SHALL have port opponent_in_game  output  1  opponent is in game mode.
REQ-010 SHALL have port link_up  output  1  a valid frame was received within the last TIMEOUT_CLKS cycles.
REQ-011 SHALL have port frame_valid  output  1  one-cycle pulse per accepted frame.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse per rejected frame.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value (rx_s).
REQ-014 SHALL decode 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-015 SHALL accept a data byte only if bits[7:5] = 3'b101 (sync marker) and bit[4] = 0; bit0 ready, bit1 game_over, bit2 victory, bit3 in_game.
REQ-016 SHALL implement the states IDLE, START, DATA, STOP, WAIT_HIGH with a bit-time counter and a 3-bit bit index.
REQ-017 IDLE: rx_s = 0 -> START, counter cleared.
REQ-018 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch, no error pulse).
REQ-019 DATA: sample rx_s every CLKS_PER_BIT cycles into the shift register; after the 8th sample -> STOP.
REQ-020 STOP: sample rx_s after CLKS_PER_BIT cycles; stop = 1 with valid marker -> accept, IDLE; stop = 1 with bad marker -> frame_error, IDLE; stop = 0 -> frame_error, WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rx_s = 1, then IDLE; a held-low line produces exactly one frame_error.
REQ-022 On accept, the cycle after the stop sample SHALL update all four flag outputs from the byte, set link_up = 1, and pulse frame_valid for one cycle.
REQ-023 On reject, flag outputs and link_up SHALL stay unchanged.
REQ-024 A timeout counter SHALL clear on accept and otherwise increment, saturating at TIMEOUT_CLKS.
REQ-025 When the counter reaches TIMEOUT_CLKS, link_up and all four flags SHALL be 0 from the next cycle on.
REQ-026 If an accept and the timeout expiry coincide, the accept SHALL win: counter cleared, flags loaded, link_up = 1.
REQ-027 frame_valid and frame_error SHALL never be high in the same cycle.
REQ-028 All outputs SHALL be registered; the counter widths SHALL hold CLKS_PER_BIT and TIMEOUT_CLKS without overflow.

Reset
REQ-029 While rst = 0 on a pclk edge: state = IDLE; counters and shift register = 0; all outputs = 0; synchronizer flops = 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, decoding restarts at the next falling edge of rx_s.

Verification (CLKS_PER_BIT = 16, TIMEOUT_CLKS = 1000)
REQ-031 Send byte 8'hA1 -> one frame_valid pulse; opponent_ready = 1, link_up = 1, other flags 0.
REQ-032 Send 8'hA1, then 8'h61 (bad marker) -> one frame_error pulse; opponent_ready stays 1, link_up stays 1.
REQ-033 Send 8'hA2 with stop bit forced to 0 and rx held low 200 cycles -> exactly one frame_error, no flag change; a following 8'hAC -> game_over = 0, victory = 1, in_game = 1.
REQ-034 Drive an rx low glitch of 4 cycles -> no frame_valid or frame_error; state back in IDLE.
REQ-035 Send 8'hA1, then idle -> link_up and opponent_ready fall exactly 1001 cycles after the frame_valid pulse; a new 8'hA1 restores both.
REQ-036 Assert rst during data bit 4 of 8'hA9 -> all outputs 0, no pulse; after release, 8'hA9 -> ready = 1, in_game = 1.
